// File: rtl/cdr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cdr_ctrl_pkg
// Shared definitions for the CDR acquisition/lock sequencer:
//   - state_t      : sequencer state encoding (IDLE=0, CAL=1, ACQ=2, TRACK=3)
//   - DEF_*        : default counter width, N0 reset value and PI gain shifts
// No ports (package).
// -----------------------------------------------------------------------------
package cdr_ctrl_pkg;

  localparam int         DEF_CNTR_BITS = 14;
  localparam int         DEF_N0_INIT   = 180;

  localparam logic [3:0] DEF_KP_ACQ    = 4'd10;
  localparam logic [4:0] DEF_KI_ACQ    = 5'd16;
  localparam logic [3:0] DEF_KP_TRK    = 4'd12;
  localparam logic [4:0] DEF_KI_TRK    = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAL   = 2'd1,
    ST_ACQ   = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

endpackage

// File: rtl/cdr_lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// cdr_lock_ctrl_if
// Bundles the sequencer's datapath-facing signals.
//   enable, Sample_en, X, PHI          : driven by the CDR side (master)
//   n0, kp_shift, ki_shift, filt_hold,
//   lock, state, cal_done, timeout     : driven by the sequencer (slave)
// Modports: master (CDR datapath / bench), slave (cdr_lock_ctrl).
// -----------------------------------------------------------------------------
interface cdr_lock_ctrl_if #(
  parameter int CNTR_BITS = cdr_ctrl_pkg::DEF_CNTR_BITS
);
  logic                  enable;
  logic                  Sample_en;
  logic signed [7:0]     X;
  logic signed [15:0]    PHI;
  logic [CNTR_BITS-1:0]  n0;
  logic [3:0]            kp_shift;
  logic [4:0]            ki_shift;
  logic                  filt_hold;
  logic                  lock;
  logic [1:0]            state;
  logic                  cal_done;
  logic                  timeout;

  modport master (
    output enable, Sample_en, X, PHI,
    input  n0, kp_shift, ki_shift, filt_hold, lock, state, cal_done, timeout
  );

  modport slave (
    input  enable, Sample_en, X, PHI,
    output n0, kp_shift, ki_shift, filt_hold, lock, state, cal_done, timeout
  );
endinterface

// File: rtl/cdr_lock_window.sv
// -----------------------------------------------------------------------------
// cdr_lock_window
// Lock-detect window: counts 2^WIN_LOG2 strobes and, within each window, the
// number of quiet samples (|PHI| <= PHI_TH).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_clr        : holds the window at its start (asserted outside ACQ/TRACK)
//   i_strobe     : symbol strobe
//   i_phi        : signed phase-detector sample
//   o_win_done   : this strobe is the last of the window
//   o_win_good   : quiet count including this sample >= LOCK_CNT
//                  (meaningful only with o_win_done)
// -----------------------------------------------------------------------------
module cdr_lock_window
  import cdr_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 6,
  parameter int PHI_TH   = 256,
  parameter int LOCK_CNT = 56
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_strobe,
  input  logic signed [15:0] i_phi,
  output logic               o_win_done,
  output logic               o_win_good
);

  localparam int QW = WIN_LOG2 + 1;

  // |v| with the single unrepresentable magnitude clamped to 32767
  function automatic logic [15:0] abs_sat16(input logic signed [15:0] v);
    logic [15:0] mag;
    if (v == 16'sh8000)
      mag = 16'h7FFF;
    else if (v < 0)
      mag = $unsigned(-v);
    else
      mag = $unsigned(v);
    return mag;
  endfunction

  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [QW-1:0]       r_quiet;
  logic                w_quiet;
  logic                w_last;
  logic [QW-1:0]       w_quiet_next;

  assign w_quiet      = (abs_sat16(i_phi) <= 16'(PHI_TH));
  assign w_quiet_next = r_quiet + QW'(w_quiet);
  assign w_last       = &r_win_cnt;

  assign o_win_done   = i_strobe & ~i_clr & w_last;
  assign o_win_good   = (w_quiet_next >= QW'(LOCK_CNT));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_win_cnt <= '0;
      r_quiet   <= '0;
    end else if (i_strobe) begin
      // window counter wraps naturally, starting the next window
      r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
      r_quiet   <= w_last ? '0 : w_quiet_next;
    end
  end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// -----------------------------------------------------------------------------
// cdr_lock_ctrl
// Acquisition/lock sequencer for the baud-rate PAM4 CDR loop.
// IDLE -> CAL (settle, then average X to re-centre n0) -> ACQ (acquisition
// gains, windowed |PHI| lock detect) -> TRACK (tracking gains); repeated bad
// windows in TRACK fall back to ACQ. enable=0 returns to IDLE from anywhere.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : cdr_lock_ctrl_if.slave (enable, Sample_en, X, PHI in;
//          n0, kp_shift, ki_shift, filt_hold, lock, state, cal_done,
//          timeout out -- all outputs registered)
// Build option: CDR_LOCK_TIMEOUT_EN -- when defined, ACQ gives up after
// ACQ_MAX_WIN windows, pulses timeout and recalibrates; otherwise timeout=0.
// -----------------------------------------------------------------------------
module cdr_lock_ctrl
  import cdr_ctrl_pkg::*;
#(
  parameter int         CNTR_BITS   = DEF_CNTR_BITS,
  parameter int         N0_INIT     = DEF_N0_INIT,
  parameter int         SETTLE_UIS  = 256,
  parameter int         CAL_LOG2    = 6,
  parameter int         WIN_LOG2    = 6,
  parameter int         PHI_TH      = 256,
  parameter int         LOCK_CNT    = 56,
  parameter int         GOOD_WINS   = 4,
  parameter int         BAD_WINS    = 2,
  parameter logic [3:0] KP_ACQ      = DEF_KP_ACQ,
  parameter logic [4:0] KI_ACQ      = DEF_KI_ACQ,
  parameter logic [3:0] KP_TRK      = DEF_KP_TRK,
  parameter logic [4:0] KI_TRK      = DEF_KI_TRK,
  parameter int         ACQ_MAX_WIN = 64
) (
  input  logic            clk,
  input  logic            rst,
  cdr_lock_ctrl_if.slave  bus
);

  localparam int SW    = $clog2(SETTLE_UIS + 1);
  localparam int SUM_W = 8 + CAL_LOG2;
  localparam int NW    = CNTR_BITS + SUM_W + 1;
  localparam int GW    = $clog2(GOOD_WINS + 1);
  localparam int BW    = $clog2(BAD_WINS + 1);

  // n0 + mean, clamped into the counter's unsigned range
  function automatic logic [CNTR_BITS-1:0] sat_n0(
    input logic [CNTR_BITS-1:0]    n0_cur,
    input logic signed [SUM_W-1:0] mean
  );
    logic signed [NW-1:0] t;
    logic signed [NW-1:0] n0_max;
    logic [CNTR_BITS-1:0] res;
    n0_max = $signed({{(NW-CNTR_BITS){1'b0}}, {CNTR_BITS{1'b1}}});
    t = $signed({{(NW-CNTR_BITS){1'b0}}, n0_cur}) +
        $signed({{(NW-SUM_W){mean[SUM_W-1]}}, mean});
    if (t < 0)
      res = '0;
    else if (t > n0_max)
      res = '1;
    else
      res = t[CNTR_BITS-1:0];
    return res;
  endfunction

  state_t                  r_state;
  logic [CNTR_BITS-1:0]    r_n0;
  logic [3:0]              r_kp;
  logic [4:0]              r_ki;
  logic                    r_hold;
  logic                    r_lock;
  logic                    r_cal_done;
  logic [SW-1:0]           r_settle;
  logic [CAL_LOG2-1:0]     r_cal_cnt;
  logic signed [SUM_W-1:0] r_sum;
  logic [GW-1:0]           r_good;
  logic [BW-1:0]           r_bad;

  logic signed [SUM_W-1:0] w_x_ext;
  logic signed [SUM_W-1:0] w_sum_next;
  logic signed [SUM_W-1:0] w_mean;
  logic                    w_win_clr;
  logic                    w_win_done;
  logic                    w_win_good;
  logic                    w_to_track;

  assign w_x_ext    = {{CAL_LOG2{bus.X[7]}}, bus.X};
  assign w_sum_next = r_sum + w_x_ext;
  // arithmetic shift gives floor of the mean, including the final sample
  assign w_mean     = w_sum_next >>> CAL_LOG2;

  // window only runs in ACQ/TRACK; held at its start otherwise
  assign w_win_clr  = ~bus.enable | ~((r_state == ST_ACQ) | (r_state == ST_TRACK));
  assign w_to_track = w_win_good & (r_good == GW'(GOOD_WINS - 1));

  cdr_lock_window #(
    .WIN_LOG2 (WIN_LOG2),
    .PHI_TH   (PHI_TH),
    .LOCK_CNT (LOCK_CNT)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_win_clr),
    .i_strobe   (bus.Sample_en),
    .i_phi      (bus.PHI),
    .o_win_done (w_win_done),
    .o_win_good (w_win_good)
  );

`ifdef CDR_LOCK_TIMEOUT_EN
  localparam int AW = $clog2(ACQ_MAX_WIN + 1);
  logic [AW-1:0] r_acq_win;
  logic          r_timeout;
`else
  logic w_unused_max;
  assign w_unused_max = |ACQ_MAX_WIN;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_n0       <= CNTR_BITS'(N0_INIT);
      r_kp       <= KP_ACQ;
      r_ki       <= KI_ACQ;
      r_hold     <= 1'b1;
      r_lock     <= 1'b0;
      r_cal_done <= 1'b0;
      r_settle   <= '0;
      r_cal_cnt  <= '0;
      r_sum      <= '0;
      r_good     <= '0;
      r_bad      <= '0;
`ifdef CDR_LOCK_TIMEOUT_EN
      r_acq_win  <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_cal_done <= 1'b0;
`ifdef CDR_LOCK_TIMEOUT_EN
      r_timeout  <= 1'b0;
      // ACQ window budget restarts on every ACQ entry
      if (r_state != ST_ACQ)
        r_acq_win <= '0;
`endif
      if (!bus.enable) begin
        r_state   <= ST_IDLE;
        r_hold    <= 1'b1;
        r_lock    <= 1'b0;
        r_kp      <= KP_ACQ;
        r_ki      <= KI_ACQ;
        r_settle  <= '0;
        r_cal_cnt <= '0;
        r_sum     <= '0;
        r_good    <= '0;
        r_bad     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_CAL;
            r_hold  <= 1'b1;
          end

          ST_CAL: begin
            if (bus.Sample_en) begin
              if (r_settle != SW'(SETTLE_UIS)) begin
                r_settle <= r_settle + SW'(1);
              end else begin
                r_sum     <= w_sum_next;
                r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
                if (&r_cal_cnt) begin
                  r_n0       <= sat_n0(r_n0, w_mean);
                  r_cal_done <= 1'b1;
                  r_state    <= ST_ACQ;
                  r_hold     <= 1'b0;
                  r_kp       <= KP_ACQ;
                  r_ki       <= KI_ACQ;
                  r_settle   <= '0;
                  r_sum      <= '0;
                  r_good     <= '0;
                end
              end
            end
          end

          ST_ACQ: begin
            if (w_win_done) begin
              if (w_to_track) begin
                r_state <= ST_TRACK;
                r_lock  <= 1'b1;
                r_kp    <= KP_TRK;
                r_ki    <= KI_TRK;
                r_good  <= '0;
                r_bad   <= '0;
              end else if (w_win_good) begin
                r_good  <= r_good + GW'(1);
              end else begin
                r_good  <= '0;
              end
`ifdef CDR_LOCK_TIMEOUT_EN
              if (!w_to_track) begin
                if (r_acq_win == AW'(ACQ_MAX_WIN - 1)) begin
                  r_state   <= ST_CAL;
                  r_hold    <= 1'b1;
                  r_timeout <= 1'b1;
                  r_good    <= '0;
                end else begin
                  r_acq_win <= r_acq_win + AW'(1);
                end
              end
`endif
            end
          end

          ST_TRACK: begin
            if (w_win_done) begin
              if (w_win_good) begin
                r_bad <= '0;
              end else if (r_bad == BW'(BAD_WINS - 1)) begin
                // integrator is not held: the loop keeps its state in ACQ
                r_state <= ST_ACQ;
                r_lock  <= 1'b0;
                r_kp    <= KP_ACQ;
                r_ki    <= KI_ACQ;
                r_bad   <= '0;
                r_good  <= '0;
              end else begin
                r_bad <= r_bad + BW'(1);
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.n0        = r_n0;
  assign bus.kp_shift  = r_kp;
  assign bus.ki_shift  = r_ki;
  assign bus.filt_hold = r_hold;
  assign bus.lock      = r_lock;
  assign bus.state     = r_state;
  assign bus.cal_done  = r_cal_done;
`ifdef CDR_LOCK_TIMEOUT_EN
  assign bus.timeout   = r_timeout;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdr_lock_ctrl
// Directed bench for cdr_lock_ctrl with reduced sizes: SETTLE_UIS=8,
// CAL_LOG2=4, WIN_LOG2=4, LOCK_CNT=14, GOOD_WINS=2, BAD_WINS=2.
// Strobes arrive every 2 clocks; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cdr_lock_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cdr_lock_ctrl_if #(.CNTR_BITS(14)) bus ();

  cdr_lock_ctrl #(
    .CNTR_BITS   (14),
    .N0_INIT     (180),
    .SETTLE_UIS  (8),
    .CAL_LOG2    (4),
    .WIN_LOG2    (4),
    .PHI_TH      (256),
    .LOCK_CNT    (14),
    .GOOD_WINS   (2),
    .BAD_WINS    (2),
    .ACQ_MAX_WIN (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // one strobe: high for one clock, low for one clock
  task automatic strobe(input logic signed [7:0] x, input logic signed [15:0] p);
    @(negedge clk);
    bus.Sample_en = 1'b1;
    bus.X         = x;
    bus.PHI       = p;
    @(negedge clk);
    bus.Sample_en = 1'b0;
  endtask

  task automatic strobes(input int n, input logic signed [7:0] x, input logic signed [15:0] p);
    for (int i = 0; i < n; i++) strobe(x, p);
  endtask

  // pass through IDLE into CAL, then 8 settle + 16 averaged strobes
  task automatic recal(input logic signed [7:0] x_body, input logic signed [7:0] x_last);
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    strobes(23, x_body, 16'sd0);
    strobe(x_last, 16'sd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.Sample_en = 1'b0;
    bus.X         = '0;
    bus.PHI       = '0;
    repeat (3) @(negedge clk);

    chk("rst_state",    32'(bus.state),     0);
    chk("rst_n0",       32'(bus.n0),        180);
    chk("rst_kp",       32'(bus.kp_shift),  10);
    chk("rst_ki",       32'(bus.ki_shift),  16);
    chk("rst_hold",     32'(bus.filt_hold), 1);
    chk("rst_lock",     32'(bus.lock),      0);
    chk("rst_cal_done", 32'(bus.cal_done),  0);
    chk("rst_timeout",  32'(bus.timeout),   0);

    rst        = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);
    chk("idle_to_cal", 32'(bus.state), 1);
    chk("cal_hold",    32'(bus.filt_hold), 1);

    // calibration with X=+10: 180 + 10 = 190
    strobes(23, 8'sd10, 16'sd0);
    chk("cal_pre_state", 32'(bus.state), 1);
    chk("cal_pre_n0",    32'(bus.n0),    180);
    strobe(8'sd10, 16'sd0);
    chk("cal_n0",       32'(bus.n0),        190);
    chk("cal_done",     32'(bus.cal_done),  1);
    chk("cal_to_acq",   32'(bus.state),     2);
    chk("acq_hold",     32'(bus.filt_hold), 0);
    @(negedge clk);
    chk("cal_done_pulse", 32'(bus.cal_done), 0);

    // two quiet windows -> TRACK exactly on the 32nd strobe
    strobes(31, 8'sd0, 16'sd0);
    chk("acq_pre_lock",  32'(bus.lock),  0);
    chk("acq_pre_state", 32'(bus.state), 2);
    strobe(8'sd0, 16'sd0);
    chk("lock",     32'(bus.lock),     1);
    chk("trk_kp",   32'(bus.kp_shift), 12);
    chk("trk_ki",   32'(bus.ki_shift), 18);
    chk("trk_state",32'(bus.state),    3);

    // bad, good, bad: bad count reset by the good window
    strobes(16, 8'sd0, 16'sd1000);
    chk("trk_bad1", 32'(bus.state), 3);
    strobes(16, 8'sd0, 16'sd0);
    strobes(16, 8'sd0, 16'sd1000);
    chk("trk_bad_reset", 32'(bus.state), 3);
    strobes(16, 8'sd0, 16'sd1000);
    chk("loss_state", 32'(bus.state),     2);
    chk("loss_lock",  32'(bus.lock),      0);
    chk("loss_kp",    32'(bus.kp_shift),  10);
    chk("loss_ki",    32'(bus.ki_shift),  16);
    chk("loss_hold",  32'(bus.filt_hold), 0);

    // threshold boundaries: 13 quiet is bad, 257 is loud, +-256 is quiet
    strobes(13, 8'sd0, 16'sd0);
    strobes(3, 8'sd0, 16'sd257);
    chk("win_13_bad", 32'(bus.state), 2);
    strobes(7, 8'sd0, 16'sd256);
    strobes(7, 8'sd0, -16'sd256);
    strobes(2, 8'sd0, 16'sd257);
    chk("win_14_good_one", 32'(bus.state), 2);
    strobes(16, 8'sd0, 16'sd0);
    chk("win_14_good_lock", 32'(bus.state), 3);

    // full-scale negative PHI is loud
    strobes(32, 8'sd0, -16'sd32768);
    chk("neg_fs_loss", 32'(bus.state), 2);
    strobes(48, 8'sd0, -16'sd32768);
    chk("neg_fs_state", 32'(bus.state), 2);
    chk("neg_fs_lock",  32'(bus.lock),  0);
    chk("no_timeout",   32'(bus.timeout), 0);

    // enable drop mid-ACQ
    strobes(5, 8'sd0, 16'sd0);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("dis_state", 32'(bus.state),     0);
    chk("dis_hold",  32'(bus.filt_hold), 1);
    chk("dis_n0",    32'(bus.n0),        190);
    chk("dis_lock",  32'(bus.lock),      0);

    // recalibration from current n0
    recal(-8'sd90, -8'sd90);
    chk("recal_100",      32'(bus.n0),       100);
    chk("recal_100_done", 32'(bus.cal_done), 1);
    recal(-8'sd128, -8'sd128);
    chk("sat_low", 32'(bus.n0), 0);
    recal(8'sd50, 8'sd50);
    chk("recal_50", 32'(bus.n0), 50);
    recal(-8'sd3, -8'sd3);
    chk("recal_m3", 32'(bus.n0), 47);
    recal(8'sd0, -8'sd1);
    chk("floor_shift", 32'(bus.n0), 46);

    // reset mid-CAL discards the partial sum and restores N0_INIT
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    strobes(13, 8'sd100, 16'sd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 32'(bus.state), 0);
    chk("rst_mid_n0",    32'(bus.n0),    180);
    rst = 1'b0;
    recal(8'sd10, 8'sd10);
    chk("rst_mid_recal", 32'(bus.n0),    190);
    chk("rst_mid_acq",   32'(bus.state), 2);

    // 64 loud ACQ windows
    strobes(63 * 16, 8'sd0, 16'sd1000);
    chk("to_pre_state",   32'(bus.state),   2);
    chk("to_pre_timeout", 32'(bus.timeout), 0);
    strobes(16, 8'sd0, 16'sd1000);
`ifdef CDR_LOCK_TIMEOUT_EN
    chk("to_state",   32'(bus.state),   1);
    chk("to_timeout", 32'(bus.timeout), 1);
    chk("to_hold",    32'(bus.filt_hold), 1);
    @(negedge clk);
    chk("to_pulse",   32'(bus.timeout), 0);
`else
    chk("no_to_state",   32'(bus.state),   2);
    chk("no_to_timeout", 32'(bus.timeout), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
